// File: rtl/digdug_scandoubler.sv
// digdug_scandoubler: 6 MHz -> 12 MHz line doubler for the DigDug video path.
// Each input line is captured into one half of a ping-pong buffer while the
// other half is replayed twice, producing 31 kHz progressive video with its
// own sync/blank timing. Everything runs on CLK48M; IN_PCLK is sampled as a
// level and edge-detected.
// Optional build macro: SCANLINE_EN (dims the second replay of every line).
module digdug_scandoubler #(
    parameter int unsigned HTOTAL     = 384,
    parameter int unsigned HACT       = 288,
    parameter logic [8:0]  HIN_START  = 9'd0,
    parameter logic [8:0]  HIN_WRAP   = 9'd0,
    parameter logic [8:0]  OHS_START  = 9'd304,
    parameter logic [8:0]  OHS_WIDTH  = 9'd40,
    parameter logic [8:0]  VACT_START = 9'd16,
    parameter logic [8:0]  VACT       = 9'd224,
    parameter logic [8:0]  VS_LINE    = 9'd240
) (
    input  logic       CLK48M,
    input  logic       RESET_N,
    input  logic       IN_PCLK,
    input  logic [7:0] IN_PIX,
    input  logic [8:0] IN_HCNT,
    input  logic [8:0] IN_VCNT,
    output logic       O_CE,
    output logic [7:0] O_PIX,
    output logic       O_HS,
    output logic       O_VS,
    output logic       O_HBLK,
    output logic       O_VBLK
);

    localparam int unsigned AW       = 9;
    localparam int unsigned DEPTH    = 2 * (1 << AW);
    localparam logic [8:0]  OH_LAST  = 9'(HTOTAL - 1);
    localparam logic [8:0]  HACT_W   = 9'(HACT);
    localparam logic [8:0]  OHS_END  = OHS_START + OHS_WIDTH;
    localparam logic [8:0]  VACT_END = VACT_START + VACT;

    logic             pclk_d;
    logic [1:0]       div;
    logic             synced;
    logic             half;
    logic             rbank;
    logic [AW-1:0]    oh;
    logic [8:0]       vline;
    logic [8:0]       prev_vcnt;

    logic [7:0]       mem [0:DEPTH-1];

    logic             in_stb_c;
    logic             line_start_c;
    logic             tick_c;
    logic             emit_c;
    logic [AW:0]      wdiff_c;
    logic             wr_en_c;
    logic [7:0]       rd_pix_c;
    logic             hblk_c;
    logic             vblk_c;
    logic             hs_c;
    logic             vs_c;
    logic [7:0]       pix_c;

    // Input pixel strobe, line-start detect, write window and output tick
    always_comb begin
        in_stb_c     = IN_PCLK & ~pclk_d;
        line_start_c = in_stb_c & (IN_HCNT == HIN_WRAP);
        tick_c       = (div == 2'd3);
        emit_c       = tick_c & ~line_start_c;
        wdiff_c      = {1'b0, IN_HCNT} - {1'b0, HIN_START};
        wr_en_c      = in_stb_c & ~wdiff_c[AW] & (wdiff_c[AW-1:0] < HACT_W);
    end

    // Output pixel and timing decode for the current output position
    always_comb begin
        rd_pix_c = mem[{rbank, oh}];
        hblk_c   = ~(oh < HACT_W);
        vblk_c   = ~((vline >= VACT_START) && (vline < VACT_END));
        hs_c     = (oh >= OHS_START) && (oh < OHS_END);
        vs_c     = (vline == VS_LINE);
        pix_c    = (hblk_c | vblk_c) ? 8'h00 : rd_pix_c;
`ifdef SCANLINE_EN
        if (half) begin
            pix_c = {pix_c[7:6] >> 1, pix_c[5:3] >> 1, pix_c[2:0] >> 1};
        end
`endif
    end

    // Line buffer write port; the write bank always differs from rbank
    always_ff @(posedge CLK48M) begin
        if (wr_en_c) begin
            mem[{IN_VCNT[0], wdiff_c[AW-1:0]}] <= IN_PIX;
        end
    end

    // Output position sequencer: line start restarts, two halves per line
    always_ff @(posedge CLK48M) begin
        if (!RESET_N) begin
            pclk_d    <= 1'b0;
            div       <= 2'd0;
            synced    <= 1'b0;
            half      <= 1'b0;
            rbank     <= 1'b0;
            oh        <= '0;
            vline     <= '0;
            prev_vcnt <= '0;
        end else begin
            pclk_d <= IN_PCLK;
            if (in_stb_c) begin
                prev_vcnt <= IN_VCNT;
            end
            if (line_start_c) begin
                synced <= 1'b1;
                oh     <= '0;
                div    <= 2'd0;
                half   <= 1'b0;
                vline  <= prev_vcnt;
                rbank  <= ~IN_VCNT[0];
            end else begin
                div <= div + 2'd1;
                if (tick_c) begin
                    if (oh == OH_LAST) begin
                        if (!half) begin
                            oh   <= '0;
                            half <= 1'b1;
                        end
                    end else begin
                        oh <= oh + 9'd1;
                    end
                end
            end
        end
    end

    // Registered video outputs, updated once per output tick
    always_ff @(posedge CLK48M) begin
        if (!RESET_N) begin
            O_CE   <= 1'b0;
            O_PIX  <= 8'h00;
            O_HS   <= 1'b0;
            O_VS   <= 1'b0;
            O_HBLK <= 1'b1;
            O_VBLK <= 1'b1;
        end else begin
            O_CE <= emit_c;
            if (emit_c) begin
                if (synced) begin
                    O_PIX  <= pix_c;
                    O_HS   <= hs_c;
                    O_VS   <= vs_c;
                    O_HBLK <= hblk_c;
                    O_VBLK <= vblk_c;
                end else begin
                    O_PIX  <= 8'h00;
                    O_HS   <= 1'b0;
                    O_VS   <= 1'b0;
                    O_HBLK <= 1'b1;
                    O_VBLK <= 1'b1;
                end
            end
        end
    end

endmodule
